// File: rtl/booth_ctrl_if.sv
// booth_ctrl_if: request, datapath-status and strobe bundle between the Booth
// controller and its requester/datapath.
// The arith_cnt signal exists only when BOOTH_CTRL_STATS_EN is defined.
// master = requester/datapath side, slave = booth_ctrl.
interface booth_ctrl_if #(
  parameter int CNTW = 5
);
  logic start;
  logic q0;
  logic qm1;
  logic eqz;
  logic lda;
  logic ldq;
  logic ldm;
  logic clra;
  logic clrq;
  logic clrff;
  logic sfta;
  logic sftq;
  logic addsub;
  logic ldcnt;
  logic decr;
  logic busy;
  logic done;
`ifdef BOOTH_CTRL_STATS_EN
  logic [CNTW-1:0] arith_cnt;
`endif

  modport master (
    output start, q0, qm1, eqz,
    input  lda, ldq, ldm, clra, clrq, clrff, sfta, sftq,
    input  addsub, ldcnt, decr, busy,
`ifdef BOOTH_CTRL_STATS_EN
    input  arith_cnt,
`endif
    input  done
  );

  modport slave (
    input  start, q0, qm1, eqz,
    output lda, ldq, ldm, clra, clrq, clrff, sfta, sftq,
    output addsub, ldcnt, decr, busy,
`ifdef BOOTH_CTRL_STATS_EN
    output arith_cnt,
`endif
    output done
  );
endinterface

// File: rtl/booth_ctrl.sv
// booth_ctrl: control FSM for the 16-bit Booth multiplier datapath.
// Loads M then Q, runs NBITS check/shift iterations and pulses done.
// Every multiply takes a fixed 36 cycles regardless of operand values.
// Optional feature macro: BOOTH_CTRL_STATS_EN adds arith_cnt, the number of
// add/subtract iterations taken by the last multiply.
//
// state  | meaning
// IDLE   | waiting for start, ALU idles in add mode
// LDM    | load multiplicand, clear A and Q[-1], load counter with NBITS
// LDQ    | load multiplier
// CHECK  | eqz ends the run, else add/sub M into A per {Q0,Q-1}
// SHIFT  | arithmetic right shift of {A,Q,Q-1}, decrement counter
// DONE   | product valid in {A,Q}, one-cycle done pulse
module booth_ctrl #(
  parameter int NBITS = 16,
  parameter int CNTW  = 5
) (
  input  logic        clk,
  input  logic        rst,
  booth_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LDM   = 3'd1,
    S_LDQ   = 3'd2,
    S_CHECK = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  // set while reset is held, cleared by the first clock after release
  logic rst_exit_q;

  // shifts seen since LDM; only used to cross-check the datapath counter
  logic [CNTW-1:0] shift_cnt_q, shift_cnt_d;

  logic lda_c, ldq_c, ldm_c, clra_c, clrff_c;
  logic sfta_c, sftq_c, addsub_c, ldcnt_c, decr_c, done_c;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // reset-exit marker used to clear a stale Q once after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_exit_q <= 1'b1;
    end else begin
      rst_exit_q <= 1'b0;
    end
  end

  // next state and strobe decode; lda/addsub also look at {q0,qm1} in CHECK
  always_comb begin
    state_d  = state_q;
    lda_c    = 1'b0;
    ldq_c    = 1'b0;
    ldm_c    = 1'b0;
    clra_c   = 1'b0;
    clrff_c  = 1'b0;
    sfta_c   = 1'b0;
    sftq_c   = 1'b0;
    addsub_c = 1'b1;
    ldcnt_c  = 1'b0;
    decr_c   = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LDM;
        end
      end
      S_LDM: begin
        ldm_c   = 1'b1;
        clra_c  = 1'b1;
        clrff_c = 1'b1;
        ldcnt_c = 1'b1;
        state_d = S_LDQ;
      end
      S_LDQ: begin
        ldq_c   = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.eqz) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
          case ({bus.q0, bus.qm1})
            2'b10: begin
              lda_c    = 1'b1;
              addsub_c = 1'b0;
            end
            2'b01: begin
              lda_c    = 1'b1;
            end
            default: begin
              lda_c    = 1'b0;
            end
          endcase
        end
      end
      S_SHIFT: begin
        sfta_c  = 1'b1;
        sftq_c  = 1'b1;
        decr_c  = 1'b1;
        state_d = S_CHECK;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // addsub defaults high, so it is forced low while reset is held to keep
  // every output at 0 in reset
  assign bus.lda    = lda_c;
  assign bus.ldq    = ldq_c;
  assign bus.ldm    = ldm_c;
  assign bus.clra   = clra_c;
  assign bus.clrff  = clrff_c;
  assign bus.sfta   = sfta_c;
  assign bus.sftq   = sftq_c;
  assign bus.addsub = addsub_c & ~rst;
  assign bus.ldcnt  = ldcnt_c;
  assign bus.decr   = decr_c;
  assign bus.done   = done_c;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.clrq   = rst_exit_q & ~rst;

  // shift tally next value: restart in LDM, count every SHIFT
  always_comb begin
    shift_cnt_d = shift_cnt_q;
    if (state_q == S_LDM) begin
      shift_cnt_d = '0;
    end else if (state_q == S_SHIFT) begin
      shift_cnt_d = shift_cnt_q + CNTW'(1);
    end
  end

  // shift tally register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_cnt_q <= '0;
    end else begin
      shift_cnt_q <= shift_cnt_d;
    end
  end

`ifdef BOOTH_CTRL_STATS_EN
  logic [CNTW-1:0] arith_cnt_q, arith_cnt_d;

  // arith_cnt next value: clear in LDM, count CHECK cycles that load A
  always_comb begin
    arith_cnt_d = arith_cnt_q;
    if (state_q == S_LDM) begin
      arith_cnt_d = '0;
    end else if (lda_c) begin
      arith_cnt_d = arith_cnt_q + CNTW'(1);
    end
  end

  // arith_cnt register; holds from DONE until the next LDM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arith_cnt_q <= '0;
    end else begin
      arith_cnt_q <= arith_cnt_d;
    end
  end

  assign bus.arith_cnt = arith_cnt_q;
`endif

  // the datapath counter must reach zero exactly after NBITS shifts
  a_eqz_after_nbits: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_CHECK && bus.eqz) |-> (shift_cnt_q == CNTW'(NBITS)));

  // A is never loaded and shifted in the same cycle
  a_lda_sfta_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.lda && bus.sfta));

  // the stale-Q clear never overlaps an operation
  a_clrq_idle: assert property (@(posedge clk) disable iff (rst)
    bus.clrq |-> !bus.busy);

endmodule

// File: tb/tb_booth_ctrl.sv
`timescale 1ns/1ps
module tb_booth_ctrl;
  localparam int NBITS = 16;
  localparam int CNTW  = 5;

  localparam int B_LDM = 12, B_CLRA = 11, B_CLRFF = 10, B_LDCNT = 9, B_LDQ = 8;
  localparam int B_LDA = 7, B_ADDSUB = 6, B_SFTA = 5, B_SFTQ = 4, B_DECR = 3;
  localparam int B_BUSY = 2, B_DONE = 1, B_CLRQ = 0;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [15:0] m;
    logic [31:0] prod;
    logic [15:0] sub_mask;
    logic [15:0] add_mask;
    int          arith;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_ctrl_if #(.CNTW(CNTW)) bif();

  booth_ctrl #(.NBITS(NBITS), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  // behavioural datapath: A, Q, M, Q[-1] and the iteration counter
  logic [15:0]     dp_a   = '0;
  logic [15:0]     dp_q   = '0;
  logic [15:0]     dp_m   = '0;
  logic            dp_qm1 = 1'b0;
  logic [CNTW-1:0] dp_cnt = '0;
  logic [15:0]     op_q   = '0;
  logic [15:0]     op_m   = '0;

  assign bif.q0  = dp_q[0];
  assign bif.qm1 = dp_qm1;
  assign bif.eqz = (dp_cnt == '0);

  always @(posedge clk) begin
    if (bif.ldm)   dp_m   <= op_m;
    if (bif.clra)  dp_a   <= '0;
    if (bif.clrff) dp_qm1 <= 1'b0;
    if (bif.ldcnt) dp_cnt <= CNTW'(NBITS);
    if (bif.ldq)   dp_q   <= op_q;
    if (bif.clrq)  dp_q   <= '0;
    if (bif.lda)   dp_a   <= bif.addsub ? (dp_a + dp_m) : (dp_a - dp_m);
    if (bif.sfta)  dp_a   <= {dp_a[15], dp_a[15:1]};
    if (bif.sftq) begin
      dp_q   <= {dp_a[0], dp_q[15:1]};
      dp_qm1 <= dp_q[0];
    end
    if (bif.decr)  dp_cnt <= dp_cnt - CNTW'(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bif.ldm, bif.clra, bif.clrff, bif.ldcnt, bif.ldq, bif.lda, bif.addsub,
            bif.sfta, bif.sftq, bif.decr, bif.busy, bif.done, bif.clrq};
  endfunction

  // expected strobes for cycle c after the start-sampling edge
  function automatic logic [12:0] exp_vec(input int c, input vec_t v);
    logic [12:0] e;
    int k;
    e = '0;
    e[B_ADDSUB] = 1'b1;
    e[B_BUSY]   = (c <= 35);
    if (c == 0) begin
      e[B_LDM] = 1'b1; e[B_CLRA] = 1'b1; e[B_CLRFF] = 1'b1; e[B_LDCNT] = 1'b1;
    end else if (c == 1) begin
      e[B_LDQ] = 1'b1;
    end else if (c >= 2 && c <= 33) begin
      k = (c - 2) / 2;
      if (c % 2 == 0) begin
        if (v.sub_mask[k]) begin
          e[B_LDA] = 1'b1; e[B_ADDSUB] = 1'b0;
        end else if (v.add_mask[k]) begin
          e[B_LDA] = 1'b1;
        end
      end else begin
        e[B_SFTA] = 1'b1; e[B_SFTQ] = 1'b1; e[B_DECR] = 1'b1;
      end
    end else if (c == 35) begin
      e[B_DONE] = 1'b1;
    end
    return e;
  endfunction

  // one multiply (two when start is held); optional stray start pulses at 5 and 20
  task automatic run_vec(input vec_t v, input bit inject, input bit hold);
    int ncyc, cp, bad, first_bad, sft_n, dones, done_c, ldm2_c, arith_bad;
    logic [12:0] got, ex;
    logic [15:0] sub_seen, add_seen;
    ncyc = hold ? 77 : 40;
    bad = 0; first_bad = -1; sft_n = 0; dones = 0; done_c = -1; ldm2_c = -1;
    arith_bad = 0; sub_seen = '0; add_seen = '0;
    op_q = v.q;
    op_m = v.m;
    bif.start = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cp  = (hold && c >= 37) ? c - 37 : c;
      got = outs();
      ex  = exp_vec(cp, v);
      if (got !== ex) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (got[B_LDA] && cp >= 2 && cp <= 32 && cp % 2 == 0) begin
        if (got[B_ADDSUB]) add_seen[(cp - 2) / 2] = 1'b1;
        else               sub_seen[(cp - 2) / 2] = 1'b1;
      end
      if (got[B_SFTA] && got[B_SFTQ] && got[B_DECR]) sft_n++;
      if (got[B_DONE]) begin
        dones++;
        if (done_c < 0) done_c = c;
        check({v.name, ".product"}, {dp_a, dp_q}, v.prod);
      end
      if (hold && c >= 36 && got[B_LDM] && ldm2_c < 0) ldm2_c = c;
`ifdef BOOTH_CTRL_STATS_EN
      if (cp >= 35 && bif.arith_cnt !== CNTW'(v.arith)) arith_bad++;
`endif
      bif.start = hold ? (c < 37) : (inject && (c == 5 || c == 20));
    end
    bif.start = 1'b0;
    check($sformatf("%s.strobes(first bad cycle %0d)", v.name, first_bad), bad, 0);
    check({v.name, ".sub_iters"}, sub_seen, v.sub_mask);
    check({v.name, ".add_iters"}, add_seen, v.add_mask);
    check({v.name, ".shift_pulses"}, sft_n, hold ? 32 : 16);
    check({v.name, ".done_count"}, dones, hold ? 2 : 1);
    check({v.name, ".done_cycle"}, done_c, 35);
    if (hold) check({v.name, ".ldm_after_done"}, ldm2_c - done_c, 2);
`ifdef BOOTH_CTRL_STATS_EN
    check({v.name, ".arith_cnt"}, arith_bad, 0);
`endif
  endtask

  // hold reset, check all-zero outputs, release and check the reset-exit cycle
  task automatic reset_cycle(input string tag);
    #2 rst = 1'b1;
    #1 check({tag, ".in_reset"}, outs(), 13'h0);
`ifdef BOOTH_CTRL_STATS_EN
    check({tag, ".arith_in_reset"}, bif.arith_cnt, 0);
`endif
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check({tag, ".exit_cycle"}, outs(), (13'h1 << B_ADDSUB) | (13'h1 << B_CLRQ));
    @(posedge clk);
    #1 check({tag, ".after_exit"}, outs(), 13'h1 << B_ADDSUB);
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{"q0000_m1234", 16'h0000, 16'h1234, 32'h0000_0000, 16'h0000, 16'h0000, 0};
    tbl[1] = '{"q0005_m0003", 16'h0005, 16'h0003, 32'h0000_000F, 16'h0005, 16'h000A, 4};
    tbl[2] = '{"qffff_m0007", 16'hFFFF, 16'h0007, 32'hFFFF_FFF9, 16'h0001, 16'h0000, 1};
    tbl[3] = '{"q8000_mffff", 16'h8000, 16'hFFFF, 32'h0000_8000, 16'h8000, 16'h0000, 1};
    tbl[4] = '{"q7fff_m0002", 16'h7FFF, 16'h0002, 32'h0000_FFFE, 16'h0001, 16'h8000, 2};
    tbl[5] = '{"qaaaa_m0001", 16'hAAAA, 16'h0001, 32'hFFFF_AAAA, 16'hAAAA, 16'h5554, 15};

    bif.start = 1'b0;
    reset_cycle("power_on");

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], 1'b0, 1'b0);
    end

    run_vec(tbl[1], 1'b1, 1'b0);
    tbl[1].name = "held_start";
    run_vec(tbl[1], 1'b0, 1'b1);

    // reset in cycle 10 of a run, then a clean run afterwards
    op_q = 16'h0005;
    op_m = 16'h0003;
    bif.start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      bif.start = 1'b0;
    end
    check("mid_run.busy_before_reset", bif.busy, 1'b1);
    reset_cycle("mid_run");
    run_vec(tbl[2], 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
